// File: rtl/fifo_to_mem_mq.sv
// Multi-queue packet writer: drains a tagged FWFT FIFO into per-queue circular
// SRAM regions as two-beat QDR bursts, dropping packets for disabled/full queues.
module fifo_to_mem_mq #(
  parameter int NUM_QUEUES      = 4,
  parameter int QID_WIDTH       = $clog2(NUM_QUEUES),
  parameter int FIFO_DATA_WIDTH = 144,
  parameter int MEM_ADDR_WIDTH  = 19,
  parameter int QADDR_WIDTH     = MEM_ADDR_WIDTH - QID_WIDTH,
  parameter int HEADROOM        = 64,
  parameter int TAIL_DELAY      = 15,
  parameter int CNT_WIDTH       = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  output logic                              fifo_rd_en,
  input  logic [FIFO_DATA_WIDTH-1:0]        fifo_data,
  input  logic [QID_WIDTH-1:0]              fifo_qid,
  input  logic                              fifo_eop,
  input  logic                              fifo_empty,
  output logic                              mem_ad_w_n,
  input  logic                              mem_wr_full,
  output logic [MEM_ADDR_WIDTH-1:0]         mem_ad_wr,
  output logic                              mem_d_w_n,
  output logic [FIFO_DATA_WIDTH/36-1:0]     mem_bwh_n,
  output logic [FIFO_DATA_WIDTH/36-1:0]     mem_bwl_n,
  output logic [FIFO_DATA_WIDTH/2-1:0]      mem_dwh,
  output logic [FIFO_DATA_WIDTH/2-1:0]      mem_dwl,
  input  logic [NUM_QUEUES*QADDR_WIDTH-1:0] q_addr_head,
  output logic [NUM_QUEUES*QADDR_WIDTH-1:0] q_addr_tail,
  input  logic [NUM_QUEUES-1:0]             q_en,
  output logic [NUM_QUEUES*CNT_WIDTH-1:0]   q_drop_cnt,
  output logic [CNT_WIDTH-1:0]              underrun_cnt,
  input  logic                              cal_done
);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DROP} state_t;

  // Occupancy at or above this level (modulo region size) means "no headroom".
  localparam logic [QADDR_WIDTH-1:0] FULL_LEVEL = QADDR_WIDTH'(-HEADROOM);

  state_t                      state;
  logic [QID_WIDTH-1:0]        cur_q;
  logic                        pad;
  logic [QADDR_WIDTH-1:0]      tail     [NUM_QUEUES];
  logic [QADDR_WIDTH-1:0]      head     [NUM_QUEUES];
  logic [CNT_WIDTH-1:0]        drop_cnt [NUM_QUEUES];
  logic [NUM_QUEUES*QADDR_WIDTH-1:0] tail_flat;
  logic [QADDR_WIDTH-1:0]      used;
  logic                        q_full;

  assign mem_bwh_n = '0;
  assign mem_bwl_n = '0;

  for (genvar i = 0; i < NUM_QUEUES; i++) begin : g_pack
    assign head[i] = q_addr_head[i*QADDR_WIDTH +: QADDR_WIDTH];
    assign tail_flat[i*QADDR_WIDTH +: QADDR_WIDTH] = tail[i];
    assign q_drop_cnt[i*CNT_WIDTH +: CNT_WIDTH] = drop_cnt[i];
  end

  always_comb begin
    used   = tail[fifo_qid] - head[fifo_qid];
    q_full = (used >= FULL_LEVEL);
  end

  always_comb begin
    fifo_rd_en = 1'b0;
    unique case (state)
      BEAT0:   fifo_rd_en = !fifo_empty && !mem_wr_full && cal_done;
      BEAT1:   fifo_rd_en = !pad && !fifo_empty;
      DROP:    fifo_rd_en = !fifo_empty;
      default: fifo_rd_en = 1'b0;
    endcase
  end

  // BEAT1 always completes the burst; a missing word becomes a zero pad beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cur_q        <= '0;
      pad          <= 1'b0;
      mem_ad_w_n   <= 1'b1;
      mem_d_w_n    <= 1'b1;
      mem_ad_wr    <= '0;
      mem_dwh      <= '0;
      mem_dwl      <= '0;
      underrun_cnt <= '0;
      for (int i = 0; i < NUM_QUEUES; i++) begin
        tail[i]     <= '0;
        drop_cnt[i] <= '0;
      end
    end else begin
      mem_ad_w_n <= 1'b1;
      mem_d_w_n  <= 1'b1;
      unique case (state)
        IDLE: begin
          if (!fifo_empty) begin
            cur_q <= fifo_qid;
            state <= (!q_en[fifo_qid] || q_full) ? DROP : BEAT0;
          end
        end
        BEAT0: begin
          if (fifo_rd_en) begin
            mem_ad_w_n           <= 1'b0;
            mem_d_w_n            <= 1'b0;
            mem_ad_wr            <= {cur_q, tail[cur_q]};
            {mem_dwh, mem_dwl}   <= fifo_data;
            pad                  <= fifo_eop;
            state                <= BEAT1;
          end
        end
        BEAT1: begin
          mem_d_w_n   <= 1'b0;
          tail[cur_q] <= tail[cur_q] + 1'b1;
          if (fifo_rd_en) begin
            {mem_dwh, mem_dwl} <= fifo_data;
            state              <= fifo_eop ? IDLE : BEAT0;
          end else begin
            {mem_dwh, mem_dwl} <= '0;
            if (!pad && underrun_cnt != '1)
              underrun_cnt <= underrun_cnt + 1'b1;
            state <= pad ? IDLE : BEAT0;
          end
        end
        DROP: begin
          if (!fifo_empty && fifo_eop) begin
            if (drop_cnt[cur_q] != '1)
              drop_cnt[cur_q] <= drop_cnt[cur_q] + 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  if (TAIL_DELAY == 0) begin : g_no_delay
    assign q_addr_tail = tail_flat;
  end else begin : g_delay
    logic [NUM_QUEUES*QADDR_WIDTH-1:0] dly [TAIL_DELAY];
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < TAIL_DELAY; i++) dly[i] <= '0;
      end else begin
        dly[0] <= tail_flat;
        for (int i = 1; i < TAIL_DELAY; i++) dly[i] <= dly[i-1];
      end
    end
    assign q_addr_tail = dly[TAIL_DELAY-1];
  end

endmodule
